dbg_abs_cmd_ctrl: RTL and testbench
===================================

# dbg_abs_cmd_ctrl

Abstract-command sequencer between the Debug Module's `command`/`data0` registers and the core debug FSM's abstract register access port (`dbg_ar_*`). It decodes RISC-V Debug "Access Register" commands and checks legality and halt state. It then issues exactly one register read or write, returns read data to `data0`, and maintains `busy` and sticky `cmderr`. It is the only master of the `dbg_ar_*` port.

## Interface
- `RD_LAT`, default 1: read latency in cycles from the `dbg_ar_en_o` cycle to `dbg_ar_di_i` valid; legal range 1..7.

- `clk_i`  in  1  clock; all logic on rising edge
- `reset_i`  in  1  synchronous, active-high reset
- `cmd_valid_i`  in  1  one-cycle pulse: DM `command` register written
- `cmd_i`  in  32  command word
  - [31:24] cmdtype
  - [22:20] aarsize
  - [19] aarpostincrement
  - [18] postexec
  - [17] transfer
  - [16] write
  - [15:0] regno
- `data0_i`  in  32  current DM `data0`, sampled on accept
- `cmderr_clr_i`  in  1  clears `cmderr_o` to 0
- `core_halted_i`  in  1  core halted (from debug FSM)
- `dbg_ar_di_i`  in  32  register read data
- `dbg_ar_en_o`  out  1  access strobe, one cycle per command
- `dbg_ar_wr_o`  out  1  1 = write
- `dbg_ar_ad_o`  out  16  regno
- `dbg_ar_do_o`  out  32  write data
- `data0_o`  out  32  read result
- `data0_we_o`  out  1  one-cycle pulse: DM loads `data0_o`
- `regno_o`  out  16  regno+1 for postincrement
- `regno_we_o`  out  1  one-cycle pulse: DM updates `command.regno`
- `busy_o`  out  1  command in progress
- `cmderr_o`  out  3  sticky error: 0 none, 1 busy, 2 not supported, 3 exception, 4 halt/resume

## Operation
- **Reset:** all outputs 0, state IDLE, latched command 0, latency counter 0.
- **States:** IDLE, CHECK, ACCESS, WAIT, DONE.
  - `busy_o` = (state != IDLE).
  - `dbg_ar_en_o` = (state == ACCESS).
  - `dbg_ar_wr_o`, `dbg_ar_ad_o` and `dbg_ar_do_o` are driven from the latched command/data and are 0 outside ACCESS.
- **IDLE:**
  - `cmd_valid_i` with `cmderr_o == 0`: latch `cmd_i` and `data0_i`, go to CHECK.
  - `cmd_valid_i` with `cmderr_o != 0`: command ignored, stay in IDLE.
- **CHECK** (first matching rule wins):
  1. cmdtype != 0, or postexec = 1, or (transfer = 1 and aarsize != 2): `cmderr` := 2, go to IDLE.
  2. transfer = 0: go to DONE (no access).
  3. `core_halted_i` = 0: `cmderr` := 4, go to IDLE.
  4. regno outside 0x0000–0x0FFF (CSR) and 0x1000–0x103F (GPR/FPR): `cmderr` := 3, go to IDLE.
  5. Otherwise: go to ACCESS.
- **ACCESS:**
  - Write: go to DONE.
  - Read: load counter with RD_LAT−1, go to WAIT.
- **WAIT:**
  - Counter != 0: decrement, stay in WAIT.
  - Counter == 0: capture `dbg_ar_di_i` into `data0_o`, go to DONE.
  - `core_halted_i` = 0 in any WAIT cycle: `cmderr` := 4, go to IDLE, no `data0_we_o`.
- **DONE:**
  - `data0_we_o` = 1 if the command was a read with transfer = 1.
  - `regno_we_o` = aarpostincrement, with `regno_o` = regno+1 (16-bit wrap, 0xFFFF → 0x0000).
  - Go to IDLE.
  - Postincrement also applies when transfer = 0.
- **Errors and clear:**
  - `cmd_valid_i` while `busy_o` = 1: `cmderr` := 1 if currently 0; the running command continues unaffected.
  - `cmderr_o` is sticky: it is set only when 0, and cleared only by `cmderr_clr_i` or reset.
  - `cmderr_clr_i` and `cmd_valid_i` in the same IDLE cycle: the clear takes effect and the command is accepted.
  - `cmderr_clr_i` and a new error in the same cycle: the error wins.
- **Halt lost in ACCESS:** the access still issues and completes; the halt check is repeated only in WAIT.
- **Reset mid-command:** returns to IDLE on the next edge; no pulses are emitted.

## Timing
- `cmd_valid_i` accepted at edge T: CHECK in T+1 and `busy_o` = 1 from T+1.
- Write: ACCESS (`dbg_ar_en_o`) in T+2, DONE in T+3, `busy_o` = 0 in T+4.
- Read: ACCESS in T+2, then RD_LAT WAIT cycles, then DONE (`data0_we_o`). For RD_LAT = 1: WAIT in T+3, DONE in T+4, IDLE in T+5.
- transfer = 0: DONE in T+2, IDLE in T+3.
- CHECK error: `cmderr_o` valid and `busy_o` = 0 in T+2.
- `dbg_ar_en_o` is never high in two consecutive cycles and never high twice per command.

## Test plan
- **Read GPR:** halted, `cmd_i` = 0x0022_1005 (read x5) → `dbg_ar_en_o` for 1 cycle with `dbg_ar_ad_o` = 0x1005 and `dbg_ar_wr_o` = 0; drive `dbg_ar_di_i` = 0xDEAD_BEEF one cycle later → `data0_o` = 0xDEAD_BEEF with `data0_we_o` at T+4; `busy_o` low at T+5.
- **Write dpc with postincrement:** halted, `cmd_i` = 0x002B_07B1, `data0_i` = 0x8000_0100 → write strobe with `dbg_ar_ad_o` = 0x07B1 and `dbg_ar_do_o` = 0x8000_0100; `regno_o` = 0x07B2 with `regno_we_o` at T+3; no `data0_we_o`.
- **Not halted:** `core_halted_i` = 0, any legal transfer → no strobe, `cmderr_o` = 4 at T+2; a later command is ignored until `cmderr_clr_i`.
- **Busy error:** second `cmd_valid_i` at T+1 → first command completes normally, `cmderr_o` = 1.
- **Unsupported:** `cmd_i` = 0x0112_1000 (cmdtype 1) → `cmderr_o` = 2; `cmd_i` = 0x0022_2000 (regno 0x2000) → `cmderr_o` = 3 (clear between cases); no strobe in either case.
- **Halt lost / wrap:** with RD_LAT = 3, drop `core_halted_i` during WAIT → `cmderr_o` = 4, no `data0_we_o`. Separately, regno 0xFFFF with transfer = 0 and postincrement → `regno_o` = 0x0000.

Source files
------------

// File: rtl/dbg_abs_cmd_ctrl.sv
// Abstract-command sequencer: decodes DM Access Register commands
// and drives one access per command on the dbg_ar_* port.
module dbg_abs_cmd_ctrl #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cmd_valid_i,
  input  logic [31:0] cmd_i,
  input  logic [31:0] data0_i,
  input  logic        cmderr_clr_i,
  input  logic        core_halted_i,
  input  logic [31:0] dbg_ar_di_i,
  output logic        dbg_ar_en_o,
  output logic        dbg_ar_wr_o,
  output logic [15:0] dbg_ar_ad_o,
  output logic [31:0] dbg_ar_do_o,
  output logic [31:0] data0_o,
  output logic        data0_we_o,
  output logic [15:0] regno_o,
  output logic        regno_we_o,
  output logic        busy_o,
  output logic [2:0]  cmderr_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_BUSY   = 3'd1;
  localparam logic [2:0] ERR_NOTSUP = 3'd2;
  localparam logic [2:0] ERR_EXC    = 3'd3;
  localparam logic [2:0] ERR_HALT   = 3'd4;

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  state_e      state_q, state_d;
  logic [31:0] cmd_q, cmd_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  cmderr_q, cmderr_d;
  logic [2:0]  fsm_err;
  logic [2:0]  new_err;
  logic        busy_err;

  logic [7:0]  cmdtype;
  logic [2:0]  aarsize;
  logic        postinc;
  logic        postexec;
  logic        transfer;
  logic        write;
  logic [15:0] regno;
  logic        unsup;
  logic        unused_rsvd;

  assign cmdtype     = cmd_q[31:24];
  assign aarsize     = cmd_q[22:20];
  assign postinc     = cmd_q[19];
  assign postexec    = cmd_q[18];
  assign transfer    = cmd_q[17];
  assign write       = cmd_q[16];
  assign regno       = cmd_q[15:0];
  assign unused_rsvd = cmd_q[23];

  assign unsup = (cmdtype != 8'd0) || postexec ||
                 (transfer && (aarsize != 3'd2));

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    fsm_err = ERR_NONE;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i &&
            ((cmderr_q == ERR_NONE) || cmderr_clr_i)) begin
          cmd_d   = cmd_i;
          wdata_d = data0_i;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // First matching rule wins.
        if (unsup) begin
          fsm_err = ERR_NOTSUP;
          state_d = S_IDLE;
        end else if (!transfer) begin
          state_d = S_DONE;
        end else if (!core_halted_i) begin
          fsm_err = ERR_HALT;
          state_d = S_IDLE;
        end else if (regno > 16'h103F) begin
          fsm_err = ERR_EXC;
          state_d = S_IDLE;
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (write) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = LAT_M1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!core_halted_i) begin
          fsm_err = ERR_HALT;
          state_d = S_IDLE;
        end else if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          rdata_d = dbg_ar_di_i;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sticky error: only a zero (or cleared) field takes a new code.
  always_comb begin
    busy_err = cmd_valid_i && (state_q != S_IDLE);
    new_err  = ERR_NONE;
    if (fsm_err != ERR_NONE) begin
      new_err = fsm_err;
    end else if (busy_err) begin
      new_err = ERR_BUSY;
    end
    cmderr_d = cmderr_clr_i ? ERR_NONE : cmderr_q;
    if ((new_err != ERR_NONE) &&
        ((cmderr_q == ERR_NONE) || cmderr_clr_i)) begin
      cmderr_d = new_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      cmderr_q <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      cmderr_q <= cmderr_d;
    end
  end

  logic acc;
  logic done;

  assign acc  = (state_q == S_ACCESS);
  assign done = (state_q == S_DONE);

  assign busy_o      = (state_q != S_IDLE);
  assign dbg_ar_en_o = acc;
  assign dbg_ar_wr_o = acc && write;
  assign dbg_ar_ad_o = acc ? regno : 16'h0;
  assign dbg_ar_do_o = acc ? wdata_q : 32'h0;

  assign data0_o    = rdata_q;
  assign data0_we_o = done && transfer && !write;
  assign regno_we_o = done && postinc;
  assign regno_o    = regno_we_o ? (regno + 16'd1) : 16'h0;
  assign cmderr_o   = cmderr_q;

endmodule

// File: tb/tb_dbg_abs_cmd_ctrl.sv
// Bench for dbg_abs_cmd_ctrl: command table with a result scoreboard,
// plus reset checks; a second instance runs with a 3-cycle read latency.
module tb_dbg_abs_cmd_ctrl;

  typedef struct {
    int          n_en;
    int          en_cyc;
    logic        wr;
    logic [15:0] ad;
    logic [31:0] dout;
    int          n_d0we;
    int          d0we_cyc;
    logic [31:0] d0;
    int          n_rnwe;
    int          rnwe_cyc;
    logic [15:0] rn;
    logic [2:0]  err;
    int          idle;
  } exp_t;

  typedef struct {
    bit          sel;
    bit          clr_with;
    bit          dbl;
    bit          post_clr;
    int          drop;
    logic        halted;
    logic [31:0] cmd;
    logic [31:0] data0;
    logic [31:0] rdata;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmderr_clr = 1'b0;
  logic        halted = 1'b1;
  logic        sel = 1'b0;
  logic [31:0] cmd = '0;
  logic [31:0] data0 = '0;
  logic [31:0] rdata_cur = '0;
  logic [31:0] di = '0;
  logic [31:0] di3 = '0;
  logic        cv_a, cv_b;

  logic        en, wr, d0we, rnwe, busy;
  logic [15:0] ad, rn;
  logic [31:0] dout, d0;
  logic [2:0]  err;
  logic        en3, wr3, d0we3, rnwe3, busy3;
  logic [15:0] ad3, rn3;
  logic [31:0] dout3, d03;
  logic [2:0]  err3;

  assign cv_a = cmd_valid & ~sel;
  assign cv_b = cmd_valid & sel;

  dbg_abs_cmd_ctrl #(.RD_LAT(1)) u_dut (
    .clk_i(clk), .reset_i(reset),
    .cmd_valid_i(cv_a), .cmd_i(cmd), .data0_i(data0),
    .cmderr_clr_i(cmderr_clr), .core_halted_i(halted),
    .dbg_ar_di_i(di),
    .dbg_ar_en_o(en), .dbg_ar_wr_o(wr),
    .dbg_ar_ad_o(ad), .dbg_ar_do_o(dout),
    .data0_o(d0), .data0_we_o(d0we),
    .regno_o(rn), .regno_we_o(rnwe),
    .busy_o(busy), .cmderr_o(err)
  );

  dbg_abs_cmd_ctrl #(.RD_LAT(3)) u_dut3 (
    .clk_i(clk), .reset_i(reset),
    .cmd_valid_i(cv_b), .cmd_i(cmd), .data0_i(data0),
    .cmderr_clr_i(cmderr_clr), .core_halted_i(halted),
    .dbg_ar_di_i(di3),
    .dbg_ar_en_o(en3), .dbg_ar_wr_o(wr3),
    .dbg_ar_ad_o(ad3), .dbg_ar_do_o(dout3),
    .data0_o(d03), .data0_we_o(d0we3),
    .regno_o(rn3), .regno_we_o(rnwe3),
    .busy_o(busy3), .cmderr_o(err3)
  );

  logic        m_en, m_wr, m_d0we, m_rnwe, m_busy;
  logic [15:0] m_ad, m_rn;
  logic [31:0] m_dout, m_d0;
  logic [2:0]  m_err;

  assign m_en   = sel ? en3   : en;
  assign m_wr   = sel ? wr3   : wr;
  assign m_ad   = sel ? ad3   : ad;
  assign m_dout = sel ? dout3 : dout;
  assign m_d0   = sel ? d03   : d0;
  assign m_d0we = sel ? d0we3 : d0we;
  assign m_rn   = sel ? rn3   : rn;
  assign m_rnwe = sel ? rnwe3 : rnwe;
  assign m_busy = sel ? busy3 : busy;
  assign m_err  = sel ? err3  : err;

  // Register file model: data valid exactly RD_LAT cycles after strobe.
  logic [7:0] sr1 = '0;
  logic [7:0] sr3 = '0;
  always @(posedge clk) begin
    sr1 = {sr1[6:0], en};
    sr3 = {sr3[6:0], en3};
    #1;
    di  = sr1[0] ? rdata_cur : 32'hBAD0_0001;
    di3 = sr3[2] ? rdata_cur : 32'hBAD0_0003;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  vec_t  vq[$];
  string nq[$];
  exp_t  sb[$];

  task automatic add(input string nm, input bit s, input bit cw,
                     input bit db, input bit pc, input int dr,
                     input logic h, input logic [31:0] c,
                     input logic [31:0] d, input logic [31:0] r,
                     input exp_t e);
    vec_t v;
    v.sel = s; v.clr_with = cw; v.dbl = db; v.post_clr = pc;
    v.drop = dr; v.halted = h; v.cmd = c; v.data0 = d;
    v.rdata = r; v.e = e;
    vq.push_back(v);
    nq.push_back(nm);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    exp_t o;
    exp_t e;
    int   zv;
    o = '{default: 0};
    o.idle = -1;
    zv = 0;
    @(posedge clk); #1;
    sel = v.sel; halted = v.halted; rdata_cur = v.rdata;
    cmd = v.cmd; data0 = v.data0;
    cmd_valid = 1'b1; cmderr_clr = v.clr_with;
    sb.push_back(v.e);
    @(posedge clk); #1;
    cmd_valid = v.dbl; cmderr_clr = 1'b0;
    if (v.dbl) begin
      cmd = 32'h0022_1005; data0 = 32'h5555_5555;
    end
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (m_en) begin
        o.n_en++; o.en_cyc = cyc;
        o.wr = m_wr; o.ad = m_ad; o.dout = m_dout;
      end else if (m_wr || m_ad != 16'h0 || m_dout != 32'h0) begin
        zv++;
      end
      if (m_d0we) begin
        o.n_d0we++; o.d0we_cyc = cyc; o.d0 = m_d0;
      end
      if (m_rnwe) begin
        o.n_rnwe++; o.rnwe_cyc = cyc; o.rn = m_rn;
      end
      if (!m_busy) begin
        o.idle = cyc; o.err = m_err;
        break;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (v.drop == cyc + 1) halted = 1'b0;
    end
    cmd_valid = 1'b0;
    halted = 1'b1;
    e = sb.pop_front();
    chk({nm, ".n_en"},     o.n_en,     e.n_en);
    chk({nm, ".en_cyc"},   o.en_cyc,   e.en_cyc);
    chk({nm, ".wr"},       o.wr,       e.wr);
    chk({nm, ".ad"},       o.ad,       e.ad);
    chk({nm, ".dout"},     o.dout,     e.dout);
    chk({nm, ".n_d0we"},   o.n_d0we,   e.n_d0we);
    chk({nm, ".d0we_cyc"}, o.d0we_cyc, e.d0we_cyc);
    chk({nm, ".d0"},       o.d0,       e.d0);
    chk({nm, ".n_rnwe"},   o.n_rnwe,   e.n_rnwe);
    chk({nm, ".rnwe_cyc"}, o.rnwe_cyc, e.rnwe_cyc);
    chk({nm, ".rn"},       o.rn,       e.rn);
    chk({nm, ".err"},      o.err,      e.err);
    chk({nm, ".idle"},     o.idle,     e.idle);
    chk({nm, ".bus_zero"}, zv,         0);
    if (v.post_clr) begin
      @(posedge clk); #1; cmderr_clr = 1'b1;
      @(posedge clk); #1; cmderr_clr = 1'b0;
      @(negedge clk);
      chk({nm, ".clr"}, m_err, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n_busy, n_pulse;
    // n_en cyc wr ad dout | n_d0we cyc d0 | n_rnwe cyc rn | err idle
    add("rd_x5", 0,0,0,0, 0, 1'b1, 32'h0022_1005, 32'h0, 32'hDEAD_BEEF,
        '{1,2,1'b0,16'h1005,32'h0, 1,4,32'hDEAD_BEEF, 0,0,16'h0, 3'd0,5});
    add("wr_dpc", 0,0,0,0, 0, 1'b1, 32'h002B_07B1, 32'h8000_0100, 32'h0,
        '{1,2,1'b1,16'h07B1,32'h8000_0100, 0,0,32'h0, 1,3,16'h07B2,
          3'd0,4});
    add("cmdtype1", 0,0,0,1, 0, 1'b1, 32'h0112_1000, 32'h0, 32'h0,
        '{0,0,1'b0,16'h0,32'h0, 0,0,32'h0, 0,0,16'h0, 3'd2,2});
    add("regno2000", 0,0,0,1, 0, 1'b1, 32'h0022_2000, 32'h0, 32'h0,
        '{0,0,1'b0,16'h0,32'h0, 0,0,32'h0, 0,0,16'h0, 3'd3,2});
    add("regno1040", 0,0,0,1, 0, 1'b1, 32'h0022_1040, 32'h0, 32'h0,
        '{0,0,1'b0,16'h0,32'h0, 0,0,32'h0, 0,0,16'h0, 3'd3,2});
    add("postexec", 0,0,0,1, 0, 1'b1, 32'h0026_1000, 32'h0, 32'h0,
        '{0,0,1'b0,16'h0,32'h0, 0,0,32'h0, 0,0,16'h0, 3'd2,2});
    add("size3_xfer", 0,0,0,1, 0, 1'b1, 32'h0032_1000, 32'h0, 32'h0,
        '{0,0,1'b0,16'h0,32'h0, 0,0,32'h0, 0,0,16'h0, 3'd2,2});
    add("size3_noxfer", 0,0,0,0, 0, 1'b1, 32'h0030_1000, 32'h0, 32'h0,
        '{0,0,1'b0,16'h0,32'h0, 0,0,32'h0, 0,0,16'h0, 3'd0,3});
    add("pinc_wrap", 0,0,0,0, 0, 1'b1, 32'h0028_FFFF, 32'h0, 32'h0,
        '{0,0,1'b0,16'h0,32'h0, 0,0,32'h0, 1,2,16'h0000, 3'd0,3});
    add("noxfer_nohalt", 0,0,0,0, 0, 1'b0, 32'h0020_0010, 32'h0, 32'h0,
        '{0,0,1'b0,16'h0,32'h0, 0,0,32'h0, 0,0,16'h0, 3'd0,3});
    add("not_halted", 0,0,0,0, 0, 1'b0, 32'h0022_1005, 32'h0, 32'h0,
        '{0,0,1'b0,16'h0,32'h0, 0,0,32'h0, 0,0,16'h0, 3'd4,2});
    add("ignored", 0,0,0,0, 0, 1'b1, 32'h0022_1005, 32'h0, 32'h1111_1111,
        '{0,0,1'b0,16'h0,32'h0, 0,0,32'h0, 0,0,16'h0, 3'd4,1});
    add("clr_accept", 0,1,0,0, 0, 1'b1, 32'h0022_1005, 32'h0,
        32'h2222_2222,
        '{1,2,1'b0,16'h1005,32'h0, 1,4,32'h2222_2222, 0,0,16'h0, 3'd0,5});
    add("rd_csr_fff", 0,0,0,0, 0, 1'b1, 32'h0022_0FFF, 32'h0,
        32'h1234_5678,
        '{1,2,1'b0,16'h0FFF,32'h0, 1,4,32'h1234_5678, 0,0,16'h0, 3'd0,5});
    add("wr_gpr_103f", 0,0,0,0, 0, 1'b1, 32'h0023_103F, 32'hCAFE_F00D,
        32'h0,
        '{1,2,1'b1,16'h103F,32'hCAFE_F00D, 0,0,32'h0, 0,0,16'h0, 3'd0,4});
    add("rd_pinc", 0,0,0,0, 0, 1'b1, 32'h002A_1000, 32'h0, 32'hA5A5_A5A5,
        '{1,2,1'b0,16'h1000,32'h0, 1,4,32'hA5A5_A5A5, 1,4,16'h1001,
          3'd0,5});
    add("busy_err", 0,0,1,1, 0, 1'b1, 32'h0023_1001, 32'h0000_0042, 32'h0,
        '{1,2,1'b1,16'h1001,32'h42, 0,0,32'h0, 0,0,16'h0, 3'd1,4});
    add("hlost_acc_wr", 0,0,0,0, 2, 1'b1, 32'h0023_1002, 32'h0000_0077,
        32'h0,
        '{1,2,1'b1,16'h1002,32'h77, 0,0,32'h0, 0,0,16'h0, 3'd0,4});
    add("hlost_acc_rd", 0,0,0,1, 2, 1'b1, 32'h0022_1003, 32'h0,
        32'h3333_3333,
        '{1,2,1'b0,16'h1003,32'h0, 0,0,32'h0, 0,0,16'h0, 3'd4,4});
    add("lat3_rd", 1,0,0,0, 0, 1'b1, 32'h0022_1008, 32'h0, 32'h1357_9BDF,
        '{1,2,1'b0,16'h1008,32'h0, 1,6,32'h1357_9BDF, 0,0,16'h0, 3'd0,7});
    add("lat3_hlost", 1,0,0,1, 4, 1'b1, 32'h0022_1009, 32'h0,
        32'h4444_4444,
        '{1,2,1'b0,16'h1009,32'h0, 0,0,32'h0, 0,0,16'h0, 3'd4,5});

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.en", en, 0);
    chk("rst.wr", wr, 0);
    chk("rst.ad", ad, 0);
    chk("rst.dout", dout, 0);
    chk("rst.d0", d0, 0);
    chk("rst.d0we", d0we, 0);
    chk("rst.rn", rn, 0);
    chk("rst.rnwe", rnwe, 0);
    chk("rst.err", err, 0);
    chk("rst.busy3", busy3, 0);

    foreach (vq[i]) run_vec(vq[i], nq[i]);

    // Reset asserted while the access strobe is up.
    sel = 1'b0;
    @(posedge clk); #1;
    cmd = 32'h0022_1005; rdata_cur = 32'h6666_6666; cmd_valid = 1'b1;
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    chk("midrst.en_before", en, 1);
    @(posedge clk); #1; reset = 1'b0;
    n_busy = 0;
    n_pulse = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (en || d0we || rnwe) n_pulse++;
    end
    chk("midrst.busy", n_busy, 0);
    chk("midrst.pulses", n_pulse, 0);
    chk("midrst.d0", d0, 0);
    chk("midrst.err", err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
